mem_arbiter: RTL and testbench

//  Shares the single 16-bit RAM (hi bank = even byte, lo bank = odd byte) between the CPU

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arbiter_lane_steer.sv | 42 ++++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the CPU/video RAM arbiter.
// In-flight state encodings, byte-lane constants and the RAM word-address width.
package mem_arbiter_pkg;

  localparam int RAM_AW = 15;
  localparam int DATA_W = 16;

  localparam logic LANE_HI = 1'b0;
  localparam logic LANE_LO = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CPU_RD = 2'd1,
    ST_CPU_WR = 2'd2,
    ST_VID_RD = 2'd3
  } flight_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU, video and RAM signals around the arbiter.
// slave: the arbiter side; master: requesters plus the RAM.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int ADDR_W = RAM_AW + 1
);
  logic              cpu_en;
  logic              cpu_wr;
  logic              cpu_wide;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_din;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_dout;

  logic              vid_req;
  logic [ADDR_W-2:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_data;

  logic              ram_en;
  logic [ADDR_W-2:0] ram_addr;
  logic              ram_we_hi;
  logic              ram_we_lo;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_din,
    output cpu_gnt, cpu_rvalid, cpu_dout,
    input  vid_req, vid_addr,
    output vid_gnt, vid_rvalid, vid_data,
    output ram_en, ram_addr, ram_we_hi, ram_we_lo, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_en, cpu_wr, cpu_wide, cpu_addr, cpu_din,
    input  cpu_gnt, cpu_rvalid, cpu_dout,
    output vid_req, vid_addr,
    input  vid_gnt, vid_rvalid, vid_data,
    input  ram_en, ram_addr, ram_we_hi, ram_we_lo, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_arbiter_lane_steer.sv
// Byte-lane steering between the CPU port and the split hi/lo RAM banks.
// Purely combinational: write enables/data for a grant, lane select for read-back.
module mem_arbiter_lane_steer import mem_arbiter_pkg::*; (
  input  logic              wr_gnt,
  input  logic              wr_wide,
  input  logic              wr_lane,
  input  logic [DATA_W-1:0] wr_din,
  output logic              we_hi,
  output logic              we_lo,
  output logic [DATA_W-1:0] wdata,
  input  logic              rd_wide,
  input  logic              rd_lane,
  input  logic [DATA_W-1:0] rd_raw,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    we_hi = 1'b0;
    we_lo = 1'b0;
    wdata = '0;
    if (wr_gnt) begin
      if (wr_wide) begin
        we_hi = 1'b1;
        we_lo = 1'b1;
        wdata = wr_din;
      end else if (wr_lane == LANE_HI) begin
        we_hi = 1'b1;
        wdata = {wr_din[7:0], 8'h00};
      end else begin
        we_lo = 1'b1;
        wdata = {8'h00, wr_din[7:0]};
      end
    end
  end

  always_comb begin
    if (rd_wide)                 rd_data = rd_raw;
    else if (rd_lane == LANE_LO) rd_data = {8'h00, rd_raw[7:0]};
    else                         rd_data = {8'h00, rd_raw[15:8]};
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: video has priority, CPU guaranteed a slot after MAX_VID_RUN.
// Optional ARB_STATS_EN adds saturating stall/grant counters as extra outputs.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int MAX_VID_RUN = 4,
  parameter int ADDR_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]  stat_cpu_stall,
  output logic [15:0]  stat_vid_grants
`endif
);

  localparam int RUN_W = $clog2(MAX_VID_RUN + 1);

  logic              guard_hit;
  logic              cpu_gnt_c;
  logic              vid_gnt_c;
  logic [RUN_W-1:0]  run_p0;
  flight_e           state_p0;
  flight_e           state_nx;
  logic              lane_p0;
  logic              wide_p0;
  logic [DATA_W-1:0] cpu_hold_p0;
  logic [DATA_W-1:0] vid_hold_p0;
  logic [DATA_W-1:0] rd_steered;
  logic              we_hi_c;
  logic              we_lo_c;
  logic [DATA_W-1:0] wdata_c;

  function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
    return (r == RUN_W'(MAX_VID_RUN)) ? r : r + RUN_W'(1);
  endfunction

  // Cycle N: grant decision, combinational from requests and the run counter.
  // Grants are suppressed while reset is high so nothing is issued that will be dropped.
  always_comb begin
    guard_hit = bus.cpu_en && (run_p0 == RUN_W'(MAX_VID_RUN));
    vid_gnt_c = !reset && bus.vid_req && !guard_hit;
    cpu_gnt_c = !reset && bus.cpu_en && !vid_gnt_c;
  end

  always_ff @(posedge clk) begin
    if (reset || !bus.cpu_en || cpu_gnt_c) run_p0 <= '0;
    else if (vid_gnt_c)                    run_p0 <= run_inc(run_p0);
  end

  mem_arbiter_lane_steer u_steer (
    .wr_gnt  (cpu_gnt_c && bus.cpu_wr),
    .wr_wide (bus.cpu_wide),
    .wr_lane (bus.cpu_addr[0]),
    .wr_din  (bus.cpu_din),
    .we_hi   (we_hi_c),
    .we_lo   (we_lo_c),
    .wdata   (wdata_c),
    .rd_wide (wide_p0),
    .rd_lane (lane_p0),
    .rd_raw  (bus.ram_rdata),
    .rd_data (rd_steered)
  );

  always_comb begin
    bus.cpu_gnt   = cpu_gnt_c;
    bus.vid_gnt   = vid_gnt_c;
    bus.ram_en    = cpu_gnt_c || vid_gnt_c;
    bus.ram_we_hi = we_hi_c;
    bus.ram_we_lo = we_lo_c;
    bus.ram_wdata = wdata_c;
    if (vid_gnt_c)      bus.ram_addr = bus.vid_addr;
    else if (cpu_gnt_c) bus.ram_addr = bus.cpu_addr[ADDR_W-1:1];
    else                bus.ram_addr = '0;
  end

  // Cycle N -> N+1: in-flight record of what the RAM is returning.
  always_ff @(posedge clk) begin
    if (reset) state_p0 <= ST_IDLE;
    else       state_p0 <= state_nx;
  end

  always_comb begin
    state_nx = ST_IDLE;
    if (vid_gnt_c)      state_nx = ST_VID_RD;
    else if (cpu_gnt_c) state_nx = bus.cpu_wr ? ST_CPU_WR : ST_CPU_RD;
  end

  always_ff @(posedge clk) begin
    if (cpu_gnt_c) begin
      lane_p0 <= bus.cpu_addr[0];
      wide_p0 <= bus.cpu_wide;
    end
  end

  // Cycle N+1: return data; hold registers keep the last delivered word.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold_p0 <= '0;
      vid_hold_p0 <= '0;
    end else begin
      if (state_p0 == ST_CPU_RD) cpu_hold_p0 <= rd_steered;
      if (state_p0 == ST_VID_RD) vid_hold_p0 <= bus.ram_rdata;
    end
  end

  always_comb begin
    bus.cpu_rvalid = (state_p0 == ST_CPU_RD) || (state_p0 == ST_CPU_WR);
    bus.vid_rvalid = (state_p0 == ST_VID_RD);
    bus.cpu_dout   = (state_p0 == ST_CPU_RD) ? rd_steered    : cpu_hold_p0;
    bus.vid_data   = (state_p0 == ST_VID_RD) ? bus.ram_rdata : vid_hold_p0;
  end

`ifdef ARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_stall  <= '0;
      stat_vid_grants <= '0;
    end else begin
      if (bus.cpu_en && !cpu_gnt_c) stat_cpu_stall  <= sat_inc16(stat_cpu_stall);
      if (vid_gnt_c)                stat_vid_grants <= sat_inc16(stat_vid_grants);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural synchronous RAM plus scoreboard queues of expected read data.
// Statistics checks are built only when ARB_STATS_EN is defined.
module tb_mem_arbiter;

  logic clk;
  logic reset;

  mem_arbiter_if #(.ADDR_W(16)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_cpu_stall;
  logic [15:0] stat_vid_grants;
`endif

  mem_arbiter #(.MAX_VID_RUN(4), .ADDR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_cpu_stall  (stat_cpu_stall),
    .stat_vid_grants (stat_vid_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a preload side-door driven by the bench.
  logic [15:0] ram_mem [0:32767];
  logic        pre_we;
  logic [14:0] pre_addr;
  logic [15:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) ram_mem[pre_addr] <= pre_data;
    if (bus.ram_en) begin
      bus.ram_rdata <= ram_mem[bus.ram_addr];
      if (bus.ram_we_hi) ram_mem[bus.ram_addr][15:8] <= bus.ram_wdata[15:8];
      if (bus.ram_we_lo) ram_mem[bus.ram_addr][7:0]  <= bus.ram_wdata[7:0];
    end
  end

  logic [15:0] shadow [0:32767];
  logic [15:0] cpu_q [$];
  logic [15:0] vid_q [$];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_read(input logic wide, input logic [15:0] addr);
    logic [15:0] w;
    w = shadow[addr[15:1]];
    if (wide) return w;
    return addr[0] ? {8'h00, w[7:0]} : {8'h00, w[15:8]};
  endfunction

  task automatic shadow_write(input logic wide, input logic [15:0] addr, input logic [15:0] din);
    if (wide)         shadow[addr[15:1]] = din;
    else if (addr[0]) shadow[addr[15:1]][7:0] = din[7:0];
    else              shadow[addr[15:1]][15:8] = din[7:0];
  endtask

  // One CPU access: waits (bounded) for the grant, captures RAM-side signals, then the N+1 result.
  task automatic cpu_access(input logic wr, input logic wide, input logic [15:0] addr,
                            input logic [15:0] din, output int waits, output logic we_hi,
                            output logic we_lo, output logic [15:0] wdata, output logic [14:0] raddr,
                            output logic rvalid, output logic [15:0] dout);
    waits = 0;
    bus.cpu_en = 1'b1; bus.cpu_wr = wr; bus.cpu_wide = wide; bus.cpu_addr = addr; bus.cpu_din = din;
    @(negedge clk);
    while (!bus.cpu_gnt && waits < 20) begin
      tick();
      waits++;
      @(negedge clk);
    end
    we_hi = bus.ram_we_hi; we_lo = bus.ram_we_lo; wdata = bus.ram_wdata; raddr = bus.ram_addr;
    tick();
    bus.cpu_en = 1'b0;
    @(negedge clk);
    rvalid = bus.cpu_rvalid;
    dout   = bus.cpu_dout;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cpu_en = 0; bus.cpu_wr = 0; bus.cpu_wide = 0; bus.cpu_addr = 0; bus.cpu_din = 0;
    bus.vid_req = 0; bus.vid_addr = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_gnt, bus.vid_gnt, bus.cpu_rvalid, bus.vid_rvalid, bus.ram_en,
         bus.ram_we_hi, bus.ram_we_lo} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 0000000", {bus.cpu_gnt, bus.vid_gnt, bus.cpu_rvalid,
               bus.vid_rvalid, bus.ram_en, bus.ram_we_hi, bus.ram_we_lo});
    end
    checks++;
    if ({bus.ram_addr, bus.ram_wdata, bus.cpu_dout, bus.vid_data} !== 63'b0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h cpu_dout=%h vid_data=%h want all 0",
               bus.ram_addr, bus.ram_wdata, bus.cpu_dout, bus.vid_data);
    end
    tick();
  endtask

  task automatic test_cpu_only();
    int w; logic hi, lo, rv; logic [15:0] wd, dout; logic [14:0] ra;
    cpu_access(1'b1, 1'b1, 16'h1000, 16'hBEEF, w, hi, lo, wd, ra, rv, dout);
    shadow_write(1'b1, 16'h1000, 16'hBEEF);
    checks++;
    if ({w, hi, lo, wd, ra, rv} !== {32'd0, 1'b1, 1'b1, 16'hBEEF, 15'h0800, 1'b1}) begin
      failures++;
      $display("FAIL cpu_wide_write: waits=%0d we=%b%b wdata=%h addr=%h rvalid=%b want 0 11 beef 0800 1",
               w, hi, lo, wd, ra, rv);
    end
    cpu_q.push_back(exp_read(1'b1, 16'h1000));
    cpu_access(1'b0, 1'b1, 16'h1000, 16'h0000, w, hi, lo, wd, ra, rv, dout);
    checks++;
    if ({w, hi, lo, rv} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL cpu_wide_read_ctl: waits=%0d we=%b%b rvalid=%b want 0 00 1", w, hi, lo, rv);
    end
    if (rv && cpu_q.size() > 0) begin
      logic [15:0] e;
      e = cpu_q.pop_front();
      checks++;
      if (dout !== e) begin
        failures++;
        $display("FAIL cpu_wide_read_data: got %h want %h", dout, e);
      end
    end
  endtask

  task automatic test_byte_lanes();
    int w; logic hi, lo, rv; logic [15:0] wd, dout, e; logic [14:0] ra;
    logic [15:0] rd_addr [3];
    logic        rd_wide [3];
    logic [15:0] rd_exp  [3];
    cpu_access(1'b1, 1'b0, 16'h2000, 16'hFF12, w, hi, lo, wd, ra, rv, dout);
    shadow_write(1'b0, 16'h2000, 16'hFF12);
    checks++;
    if ({hi, lo, wd, rv} !== {2'b10, 16'h1200, 1'b1}) begin
      failures++;
      $display("FAIL byte_write_hi: we=%b%b wdata=%h rvalid=%b want 10 1200 1", hi, lo, wd, rv);
    end
    cpu_access(1'b1, 1'b0, 16'h2001, 16'hAA34, w, hi, lo, wd, ra, rv, dout);
    shadow_write(1'b0, 16'h2001, 16'hAA34);
    checks++;
    if ({hi, lo, wd, ra} !== {2'b01, 16'h0034, 15'h1000}) begin
      failures++;
      $display("FAIL byte_write_lo: we=%b%b wdata=%h addr=%h want 01 0034 1000", hi, lo, wd, ra);
    end
    rd_addr = '{16'h2000, 16'h2001, 16'h2000};
    rd_wide = '{1'b1, 1'b0, 1'b0};
    rd_exp  = '{16'h1234, 16'h0034, 16'h0012};
    for (int i = 0; i < 3; i++) begin
      cpu_q.push_back(rd_exp[i]);
      cpu_access(1'b0, rd_wide[i], rd_addr[i], 16'h0000, w, hi, lo, wd, ra, rv, dout);
      checks++;
      if (!rv || cpu_q.size() == 0) begin
        failures++;
        $display("FAIL byte_read_%0d_valid: rvalid=%b queued=%0d want 1", i, rv, cpu_q.size());
      end else begin
        e = cpu_q.pop_front();
        if (dout !== e) begin
          failures++;
          $display("FAIL byte_read_%0d: got %h want %h", i, dout, e);
        end
      end
    end
  endtask

  task automatic test_contention();
    int stall = 0, max_stall = 0;
    logic [1:0] exp_g;
    logic [15:0] e;
    bus.vid_req = 1'b1; bus.vid_addr = 15'h0800;
    bus.cpu_en = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_wide = 1'b1; bus.cpu_addr = 16'h1000;
    for (int i = 0; i < 26; i++) begin
      if (i == 25) begin bus.vid_req = 1'b0; bus.cpu_en = 1'b0; end
      @(negedge clk);
      if (bus.cpu_rvalid) begin
        checks++;
        e = (cpu_q.size() > 0) ? cpu_q.pop_front() : 16'hxxxx;
        if (bus.cpu_dout !== e) begin
          failures++;
          $display("FAIL contend_cpu_data cycle %0d: got %h want %h", i, bus.cpu_dout, e);
        end
      end
      if (bus.vid_rvalid) begin
        checks++;
        e = (vid_q.size() > 0) ? vid_q.pop_front() : 16'hxxxx;
        if (bus.vid_data !== e) begin
          failures++;
          $display("FAIL contend_vid_data cycle %0d: got %h want %h", i, bus.vid_data, e);
        end
      end
      if (i < 25) begin
        exp_g = ((i % 5) == 4) ? 2'b01 : 2'b10;
        checks++;
        if ({bus.vid_gnt, bus.cpu_gnt} !== exp_g) begin
          failures++;
          $display("FAIL contend_grant cycle %0d: vid/cpu=%b want %b", i, {bus.vid_gnt, bus.cpu_gnt}, exp_g);
        end
        if (bus.vid_gnt) vid_q.push_back(shadow[15'h0800]);
        if (bus.cpu_gnt) begin
          cpu_q.push_back(exp_read(1'b1, 16'h1000));
          stall = 0;
        end else begin
          stall++;
          if (stall > max_stall) max_stall = stall;
        end
      end
      tick();
    end
    checks++;
    if (max_stall > 4) begin
      failures++;
      $display("FAIL contend_max_stall: got %0d want <=4", max_stall);
    end
    checks++;
    if (cpu_q.size() + vid_q.size() != 0) begin
      failures++;
      $display("FAIL contend_drain: left cpu=%0d vid=%0d want 0 0", cpu_q.size(), vid_q.size());
    end
    cpu_q.delete(); vid_q.delete();
  endtask

  task automatic test_back_to_back();
    int grants = 0;
    logic [15:0] e;
    for (int i = 0; i < 8; i++) begin
      pre_we = 1'b1; pre_addr = 15'(i); pre_data = 16'hA000 + 16'(i * 16'h0111);
      shadow[i] = pre_data;
      tick();
    end
    pre_we = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus.vid_req  = (i < 8);
      bus.vid_addr = 15'(i % 8);
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (!bus.vid_rvalid || vid_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_rvalid %0d: rvalid=%b queued=%0d want 1", i, bus.vid_rvalid, vid_q.size());
        end else begin
          e = vid_q.pop_front();
          if (bus.vid_data !== e) begin
            failures++;
            $display("FAIL b2b_data %0d: got %h want %h", i - 1, bus.vid_data, e);
          end
        end
      end
      if (i < 8 && bus.vid_gnt) begin
        grants++;
        vid_q.push_back(shadow[i]);
        checks++;
        if (bus.ram_addr !== 15'(i)) begin
          failures++;
          $display("FAIL b2b_addr %0d: got %h want %h", i, bus.ram_addr, 15'(i));
        end
      end
      tick();
    end
    checks++;
    if (grants != 8) begin
      failures++;
      $display("FAIL b2b_grants: got %0d want 8", grants);
    end
    vid_q.delete();
  endtask

  task automatic test_reset_mid();
    int w; logic hi, lo, rv; logic [15:0] wd, dout, e; logic [14:0] ra;
    bus.cpu_en = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_wide = 1'b1; bus.cpu_addr = 16'h1000;
    @(negedge clk);
    checks++;
    if (bus.cpu_gnt !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre_gnt: got %b want 1", bus.cpu_gnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.cpu_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cpu_gnt, bus.vid_gnt, bus.cpu_rvalid, bus.vid_rvalid, bus.ram_en, bus.ram_we_hi,
         bus.ram_we_lo, bus.ram_addr, bus.ram_wdata, bus.cpu_dout, bus.vid_data} !== 70'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: rvalid=%b/%b cpu_dout=%h vid_data=%h ram_en=%b want all 0",
               bus.cpu_rvalid, bus.vid_rvalid, bus.cpu_dout, bus.vid_data, bus.ram_en);
    end
    tick();
    cpu_q.push_back(exp_read(1'b1, 16'h1000));
    cpu_access(1'b0, 1'b1, 16'h1000, 16'h0000, w, hi, lo, wd, ra, rv, dout);
    e = (cpu_q.size() > 0) ? cpu_q.pop_front() : 16'hxxxx;
    checks++;
    if ({w, rv, dout} !== {32'd0, 1'b1, e}) begin
      failures++;
      $display("FAIL rstmid_next_read: waits=%0d rvalid=%b dout=%h want 0 1 %h", w, rv, dout, e);
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({stat_cpu_stall, stat_vid_grants} !== 32'h0) begin
      failures++;
      $display("FAIL stats_reset: stall=%h vid=%h want 0 0", stat_cpu_stall, stat_vid_grants);
    end
    tick();
    bus.vid_addr = 15'h0000; bus.cpu_wr = 1'b0; bus.cpu_wide = 1'b1; bus.cpu_addr = 16'h1000;
    for (int i = 0; i < 6; i++) begin
      bus.vid_req = (i < 5);
      bus.cpu_en  = (i >= 2);
      tick();
    end
    bus.vid_req = 1'b0; bus.cpu_en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({stat_cpu_stall, stat_vid_grants} !== {16'd3, 16'd5}) begin
      failures++;
      $display("FAIL stats_count: stall=%0d vid=%0d want 3 5", stat_cpu_stall, stat_vid_grants);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.vid_req = 1'b1; bus.cpu_en = 1'b1;
    repeat (82000) tick();
    bus.vid_req = 1'b0; bus.cpu_en = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if ({stat_cpu_stall, stat_vid_grants} !== 32'hffff_ffff) begin
      failures++;
      $display("FAIL stats_saturate: stall=%h vid=%h want ffff ffff", stat_cpu_stall, stat_vid_grants);
    end
    tick();
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_only();
    test_byte_lanes();
    test_contention();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
